fmul_seq_ctrl: RTL and testbench

//  Sequencing controller for the FP32 Booth partial-product multiplier stage.

---
 rtl/fmul_seq_ctrl_if.sv | 23 ++
 rtl/fmul_seq_ctrl.sv | 173 +++++++++++++++++
 tb/tb_fmul_seq_ctrl.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fmul_seq_ctrl_if.sv
// Operand-in / result-out handshake bundle for the FP32 multiply sequencer.
// The issue side uses master; the sequencer uses slave.
interface fmul_seq_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_res;
  logic        out_ovf;
  logic        out_udf;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_res, out_ovf, out_udf
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_res, out_ovf, out_udf
  );
endinterface

// File: rtl/fmul_seq_ctrl.sv
// Sequencing controller for the FP32 Booth partial-product multiplier: accumulates the
// 13 partial products over N cycles, then normalises, rounds (RNE) and returns the result.
module fmul_seq_ctrl #(
  parameter int PP_PER_CYCLE = 13
) (
  input  logic                clk,
  input  logic                rst,
  fmul_seq_ctrl_if.slave      bus,
  output logic [31:0]         mul_a,
  output logic [31:0]         mul_b,
  input  logic [636:0]        mul_pp,
  input  logic                mul_sign,
  input  logic [8:0]          mul_expc
);

  localparam int N  = (13 + PP_PER_CYCLE - 1) / PP_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int NP = N * PP_PER_CYCLE;
  localparam int IW = $clog2(NP);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    NORM  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state_r;
  logic [48:0]     acc_r;
  logic [CW-1:0]   cnt_r;
  logic            out_valid_r;
  logic [31:0]     out_res_r;
  logic            out_ovf_r;
  logic            out_udf_r;

  logic [48:0]     pp_s [NP];
  logic [48:0]     grp_sum_s;

  // Pad the partial-product list to a whole number of groups so the last group reads zeros.
  for (genvar g = 0; g < NP; g++) begin : g_pp
    if (g < 13) begin : g_real
      assign pp_s[g] = mul_pp[g*49 +: 49];
    end else begin : g_pad
      assign pp_s[g] = 49'd0;
    end
  end

  always_comb begin
    grp_sum_s = 49'd0;
    for (int j = 0; j < PP_PER_CYCLE; j++) begin
      grp_sum_s = grp_sum_s + pp_s[IW'(int'(cnt_r) * PP_PER_CYCLE + j)];
    end
  end

  logic [47:0]        prod_s;
  logic [22:0]        man_s;
  logic               g_s;
  logic               st_s;
  logic signed [10:0] e_s;
  logic               rnd_up_s;
  logic [23:0]        man_sum_s;
  logic               carry_s;
  logic signed [10:0] e_rnd_s;
  logic [22:0]        frac_s;
  logic               a_nan_s, b_nan_s, a_inf_s, b_inf_s, a_zero_s, b_zero_s;
  logic [31:0]        res_s;
  logic               ovf_s;
  logic               udf_s;

  // Normalise, round to nearest-even and classify the operands into the final result.
  always_comb begin
    prod_s = acc_r[47:0];
    if (prod_s[47]) begin
      man_s = prod_s[46:24];
      g_s   = prod_s[23];
      st_s  = |prod_s[22:0];
      e_s   = $signed({2'b00, mul_expc}) - 11'sd126;
    end else begin
      man_s = prod_s[45:23];
      g_s   = prod_s[22];
      st_s  = |prod_s[21:0];
      e_s   = $signed({2'b00, mul_expc}) - 11'sd127;
    end
    rnd_up_s  = g_s & (st_s | man_s[0]);
    man_sum_s = {1'b0, man_s} + {23'd0, rnd_up_s};
    carry_s   = man_sum_s[23];
    e_rnd_s   = e_s + (carry_s ? 11'sd1 : 11'sd0);
    frac_s    = carry_s ? 23'd0 : man_sum_s[22:0];

    a_nan_s  = (&mul_a[30:23]) & (|mul_a[22:0]);
    b_nan_s  = (&mul_b[30:23]) & (|mul_b[22:0]);
    a_inf_s  = (&mul_a[30:23]) & ~(|mul_a[22:0]);
    b_inf_s  = (&mul_b[30:23]) & ~(|mul_b[22:0]);
    a_zero_s = (mul_a[30:23] == 8'd0);
    b_zero_s = (mul_b[30:23] == 8'd0);

    ovf_s = 1'b0;
    udf_s = 1'b0;
    if (a_nan_s || b_nan_s || (a_inf_s && b_zero_s) || (b_inf_s && a_zero_s)) begin
      res_s = 32'h7FC0_0000;
    end else if (a_inf_s || b_inf_s) begin
      res_s = {mul_sign, 8'hFF, 23'd0};
    end else if (a_zero_s || b_zero_s) begin
      res_s = {mul_sign, 31'd0};
    end else if (e_rnd_s >= 11'sd255) begin
      res_s = {mul_sign, 8'hFF, 23'd0};
      ovf_s = 1'b1;
    end else if (e_rnd_s <= 11'sd0) begin
      res_s = {mul_sign, 31'd0};
      udf_s = 1'b1;
    end else begin
      res_s = {mul_sign, e_rnd_s[7:0], frac_s};
    end
  end

  // Operation sequencer; all handshake outputs except in_ready are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      acc_r       <= 49'd0;
      cnt_r       <= '0;
      mul_a       <= 32'd0;
      mul_b       <= 32'd0;
      out_valid_r <= 1'b0;
      out_res_r   <= 32'd0;
      out_ovf_r   <= 1'b0;
      out_udf_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            mul_a   <= bus.in_a;
            mul_b   <= bus.in_b;
            acc_r   <= 49'd0;
            cnt_r   <= '0;
            state_r <= ACCUM;
          end
        end
        ACCUM: begin
          acc_r <= acc_r + grp_sum_s;
          if (cnt_r == CW'(N - 1)) begin
            state_r <= NORM;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        NORM: begin
          out_res_r   <= res_s;
          out_ovf_r   <= ovf_s;
          out_udf_r   <= udf_s;
          out_valid_r <= 1'b1;
          state_r     <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_r == IDLE) && !rst;
  assign bus.out_valid = out_valid_r;
  assign bus.out_res   = out_res_r;
  assign bus.out_ovf   = out_ovf_r;
  assign bus.out_udf   = out_udf_r;

endmodule

// File: tb/tb_fmul_seq_ctrl.sv
// Randomised bench for fmul_seq_ctrl at PP_PER_CYCLE = 13, 1 and 4, checked against a
// plain-arithmetic FP32 multiply reference and a random partial-product generator.
module tb_fmul_seq_ctrl;

  logic clk;
  logic rst;

  logic         in_valid_v  [3];
  logic [31:0]  in_a_v      [3];
  logic [31:0]  in_b_v      [3];
  logic         out_ready_v [3];
  logic         in_ready_v  [3];
  logic         out_valid_v [3];
  logic [31:0]  out_res_v   [3];
  logic         out_ovf_v   [3];
  logic         out_udf_v   [3];
  logic [31:0]  mul_a_v     [3];
  logic [31:0]  mul_b_v     [3];
  logic [636:0] mul_pp_v    [3];
  logic         mul_sign_v  [3];
  logic [8:0]   mul_expc_v  [3];

  int nv [3] = '{1, 13, 4};
  int total = 0;
  int bad   = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    fmul_seq_ctrl_if bus ();
    assign bus.in_valid    = in_valid_v[g];
    assign bus.in_a        = in_a_v[g];
    assign bus.in_b        = in_b_v[g];
    assign bus.out_ready   = out_ready_v[g];
    assign in_ready_v[g]   = bus.in_ready;
    assign out_valid_v[g]  = bus.out_valid;
    assign out_res_v[g]    = bus.out_res;
    assign out_ovf_v[g]    = bus.out_ovf;
    assign out_udf_v[g]    = bus.out_udf;

    fmul_seq_ctrl #(.PP_PER_CYCLE((g == 0) ? 13 : ((g == 1) ? 1 : 4))) u_dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .mul_a    (mul_a_v[g]),
      .mul_b    (mul_b_v[g]),
      .mul_pp   (mul_pp_v[g]),
      .mul_sign (mul_sign_v[g]),
      .mul_expc (mul_expc_v[g])
    );
  end

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic string tg(input string s, input int d);
    return $sformatf("%s[pp%0d]", s, d);
  endfunction

  // Reference FP32 multiply: exact integer product, then round-half-even by comparing the remainder.
  function automatic void ref_mul(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] res, output logic ovf, output logic udf);
    logic s;
    int ea, eb, e, sh;
    longint unsigned ma, mb, prod, q, rem, half;
    s   = a[31] ^ b[31];
    ea  = int'(a[30:23]);
    eb  = int'(b[30:23]);
    ovf = 1'b0;
    udf = 1'b0;
    if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0) ||
        (ea == 255 && eb == 0) || (eb == 255 && ea == 0)) begin
      res = 32'h7FC0_0000;
    end else if (ea == 255 || eb == 255) begin
      res = {s, 8'hFF, 23'd0};
    end else if (ea == 0 || eb == 0) begin
      res = {s, 31'd0};
    end else begin
      ma   = 64'(a[22:0]) + 64'h80_0000;
      mb   = 64'(b[22:0]) + 64'h80_0000;
      prod = ma * mb;
      sh   = (prod >= (64'd1 << 47)) ? 24 : 23;
      e    = ea + eb - ((sh == 24) ? 126 : 127);
      q    = prod >> sh;
      rem  = prod & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && (q % 2) == 1)) q = q + 64'd1;
      if (q == (64'd1 << 24)) begin
        q = 64'd1 << 23;
        e = e + 1;
      end
      if (e >= 255) begin
        res = {s, 8'hFF, 23'd0};
        ovf = 1'b1;
      end else if (e <= 0) begin
        res = {s, 31'd0};
        udf = 1'b1;
      end else begin
        res = {s, 8'(e), 23'(q)};
      end
    end
  endfunction

  // PP generator stand-in: 12 random products plus one that makes the mod-2^49 sum exact.
  task automatic build_pp(input int d, input logic [31:0] a, input logic [31:0] b);
    logic [636:0] pp;
    logic [48:0]  acc, p, tgt;
    logic [47:0]  prod;
    prod = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    tgt  = {1'b0, prod};
    acc  = 49'd0;
    pp   = '0;
    for (int i = 0; i < 12; i++) begin
      p = {17'($urandom), 32'($urandom)};
      pp[i*49 +: 49] = p;
      acc = acc + p;
    end
    pp[12*49 +: 49] = tgt - acc;
    mul_pp_v[d]   = pp;
    mul_sign_v[d] = a[31] ^ b[31];
    mul_expc_v[d] = 9'(a[30:23]) + 9'(b[30:23]);
  endtask

  function automatic logic [31:0] rand_fp();
    logic [7:0]  e;
    logic [22:0] f;
    int c;
    c = $urandom_range(0, 19);
    if (c == 0)      e = 8'd0;
    else if (c == 1) e = 8'hFF;
    else             e = 8'($urandom_range(1, 254));
    case ($urandom_range(0, 2))
      0:       f = 23'($urandom);
      1:       f = 23'($urandom) & 23'h7F_0000;
      default: f = 23'd0;
    endcase
    return {1'($urandom), e, f};
  endfunction

  // One operation from IDLE; hold = cycles of out_ready=0 while the result is presented.
  task automatic run_op(input int d, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [31:0] er;
    logic        eo, eu;
    int          k;
    ref_mul(a, b, er, eo, eu);
    build_pp(d, a, b);
    in_a_v[d]      = a;
    in_b_v[d]      = b;
    in_valid_v[d]  = 1'b1;
    out_ready_v[d] = (hold == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
    #1;
    chk(tg("rdy_idle", d), 64'(in_ready_v[d]), 64'd1);
    @(posedge clk); #1;
    in_valid_v[d] = 1'b0;
    in_a_v[d]     = $urandom;
    in_b_v[d]     = $urandom;
    chk(tg("mul_a", d), 64'(mul_a_v[d]), 64'(a));
    chk(tg("mul_b", d), 64'(mul_b_v[d]), 64'(b));
    chk(tg("rdy_busy", d), 64'(in_ready_v[d]), 64'd0);
    k = 0;
    while (!out_valid_v[d] && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    chk(tg("latency", d), 64'(k + 1), 64'(nv[d] + 2));
    if (!out_valid_v[d]) begin
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      out_ready_v[d] = 1'b0;
      return;
    end
    for (int i = 0; i < hold; i++) begin
      chk(tg("hold_res", d), 64'(out_res_v[d]), 64'(er));
      chk(tg("hold_flags", d), 64'({out_ovf_v[d], out_udf_v[d]}), 64'({eo, eu}));
      chk(tg("hold_valid", d), 64'({out_valid_v[d], in_ready_v[d]}), 64'(2'b10));
      @(posedge clk); #1;
    end
    out_ready_v[d] = 1'b1;
    chk(tg($sformatf("res %h*%h", a, b), d), 64'(out_res_v[d]), 64'(er));
    chk(tg("ovf", d), 64'(out_ovf_v[d]), 64'(eo));
    chk(tg("udf", d), 64'(out_udf_v[d]), 64'(eu));
    chk(tg("valid", d), 64'(out_valid_v[d]), 64'd1);
    @(posedge clk); #1;
    out_ready_v[d] = 1'b0;
    chk(tg("drop", d), 64'({out_valid_v[d], in_ready_v[d]}), 64'(2'b01));
  endtask

  logic [31:0] dir_a [7] = '{32'h3FC0_0000, 32'hBF80_0000, 32'hC000_0000, 32'h7F00_0000,
                             32'h0080_0000, 32'h7F80_0000, 32'hFF80_0000};
  logic [31:0] dir_b [7] = '{32'h4000_0000, 32'h3F80_0000, 32'h4040_0000, 32'h7F00_0000,
                             32'h0080_0000, 32'h0000_0000, 32'h4000_0000};
  logic [31:0] dir_r [7] = '{32'h4040_0000, 32'hBF80_0000, 32'hC0C0_0000, 32'h7F80_0000,
                             32'h0000_0000, 32'h7FC0_0000, 32'hFF80_0000};

  initial begin
    logic [31:0] er;
    logic        eo, eu;
    clk = 1'b0;
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      in_valid_v[d]  = 1'b0;
      in_a_v[d]      = 32'd0;
      in_b_v[d]      = 32'd0;
      out_ready_v[d] = 1'b0;
      mul_pp_v[d]    = '0;
      mul_sign_v[d]  = 1'b0;
      mul_expc_v[d]  = 9'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk(tg("rst_ready", d), 64'(in_ready_v[d]), 64'd0);
      chk(tg("rst_out", d), 64'({out_valid_v[d], out_res_v[d], out_ovf_v[d], out_udf_v[d]}), 64'd0);
      chk(tg("rst_mul", d), {mul_a_v[d], mul_b_v[d]}, 64'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // The reference must itself reproduce the known vectors before it is trusted.
    for (int i = 0; i < 7; i++) begin
      ref_mul(dir_a[i], dir_b[i], er, eo, eu);
      chk($sformatf("ref_vec%0d", i), 64'(er), 64'(dir_r[i]));
      run_op(0, dir_a[i], dir_b[i], (i == 0) ? 5 : 0);
    end

    // Abort in the middle of accumulation at PP_PER_CYCLE = 1.
    build_pp(1, 32'h4049_0FDB, 32'h402D_F854);
    in_a_v[1] = 32'h4049_0FDB;
    in_b_v[1] = 32'h402D_F854;
    in_valid_v[1] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[1] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_rdy_in_rst", 64'(in_ready_v[1]), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("abort_idle", 64'(in_ready_v[1]), 64'd1);
    for (int i = 0; i < 16; i++) begin
      chk("abort_no_out", 64'(out_valid_v[1]), 64'd0);
      @(posedge clk); #1;
    end
    run_op(1, 32'h3F80_0000, 32'h3F80_0000, 0);

    for (int n = 0; n < 60; n++) begin
      run_op(n % 3, rand_fp(), rand_fp(), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
